mmio_bus_mapper: RTL and testbench

Parametrised data-side address decoder between the RV32 datapath and the data RAM / MMIO peripherals. It replaces the fixed-address combinational map with an N-slot peripheral window, byte-lane RAM writes, sign/zero-extended sub-word loads, and a one-cycle registered read response aligned to synchronous RAM. It also adds registered peripheral strobes and a sticky bus-error status register that software can read.

---
 rtl/mmio_map_pkg.sv | 38 +++
 rtl/mmio_bus_mapper_load_formatter.sv | 27 ++
 rtl/mmio_bus_mapper.sv | 187 ++++++++++++++++++
 tb/tb_mmio_bus_mapper.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_map_pkg.sv
// Shared types and constants for the data-side MMIO address map.
package mmio_map_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } access_size_t;

    typedef enum logic [1:0] {
        T_RAM    = 2'b00,
        T_SLOT   = 2'b01,
        T_STATUS = 2'b10,
        T_ERR    = 2'b11
    } target_t;

    localparam logic [31:0] DEFAULT_PERIPH_BASE = 32'h0000_2000;
    localparam int unsigned SLOT_STRIDE         = 4;

    // Raw size field to access size; the unused encoding 11 behaves as a word.
    function automatic access_size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    // Byte-lane enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_enables(input access_size_t sz, input logic [1:0] lane);
        case (sz)
            BYTE:    return 4'b0001 << lane;
            HALF:    return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mmio_bus_mapper_load_formatter.sv
// Combinational load formatter: picks the addressed byte/half lane out of a
// 32-bit word and sign- or zero-extends it. Word loads pass straight through.
module load_formatter
    import mmio_map_pkg::*;
(
    input  logic [31:0]  word,
    input  logic [1:0]   lane,
    input  access_size_t size,
    input  logic         sign_ext,
    output logic [31:0]  data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by extension to 32 bits.
    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (size)
            BYTE:    data = {{24{sign_ext & byte_v[7]}}, byte_v};
            HALF:    data = {{16{sign_ext & half_v[15]}}, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mmio_bus_mapper.sv
// Data-side address decoder between the RV32 datapath and data RAM / MMIO.
// Decodes status register, an N-slot word-only peripheral window and RAM,
// issues byte-lane RAM writes, registered peripheral strobes, and a
// one-cycle registered load response aligned to synchronous RAM.
//
// Handshake: requests are single-cycle strobes (we_i/re_i) with no ready;
// every accepted load (re_i without we_i) yields exactly one rvalid_o pulse
// in the following cycle, and every rejected access yields one err_o pulse
// in the following cycle.
module mmio_bus_mapper
    import mmio_map_pkg::*;
#(
    parameter int unsigned RAM_DEPTH   = 4096,
    parameter int unsigned N_SLOTS     = 8,
    parameter logic [31:0] PERIPH_BASE = DEFAULT_PERIPH_BASE,
    parameter logic [31:0] STATUS_ADDR = PERIPH_BASE + 32'(SLOT_STRIDE * N_SLOTS),
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [1:0]            size_i,
    input  logic                  signed_i,
    output logic [31:0]           rdata_o,
    output logic                  rvalid_o,
    output logic                  err_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    output logic [N_SLOTS-1:0]    p_we_o,
    output logic [N_SLOTS-1:0]    p_re_o,
    output logic [31:0]           p_wdata_o,
    input  logic [32*N_SLOTS-1:0] p_rdata_i
);

    localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [31:0] RAM_BYTES   = 32'(4 * RAM_DEPTH);
    localparam logic [31:0] WINDOW_SIZE = 32'(SLOT_STRIDE * N_SLOTS);

    // Request-cycle decode
    access_size_t         sz;
    logic [1:0]           lane;
    logic [31:0]          slot_off;
    logic [SW-1:0]        slot_idx;
    logic [N_SLOTS-1:0]   slot_onehot;
    logic [31:0]          slot_rdata;
    logic                 misalign, hit_status, hit_slot, hit_ram;
    logic                 ok, store_ok, load_issue, err_now, status_wr;
    target_t              load_target;

    // Status register fields
    logic [7:0]           err_count;
    logic [15:0]          last_err_addr;
    logic [31:0]          status_word;

    // Load stage and registered strobes
    logic                 rvalid_q, err_q;
    target_t              ld_target;
    logic [1:0]           ld_lane;
    access_size_t         ld_size;
    logic                 ld_signed;
    logic [31:0]          ld_data;
    logic [N_SLOTS-1:0]   p_we_q, p_re_q;
    logic [31:0]          fmt_src, fmt_data;

    assign status_word = {err_count, 8'h00, last_err_addr};

    // Address decode, alignment check and target classification.
    always_comb begin
        sz          = decode_size(size_i);
        lane        = addr_i[1:0];
        slot_off    = addr_i - PERIPH_BASE;
        slot_idx    = slot_off[SW+1:2];
        misalign    = ((sz == WORD) && (lane != 2'b00)) || ((sz == HALF) && lane[0]);
        hit_status  = (addr_i == STATUS_ADDR);
        hit_slot    = !hit_status && (addr_i >= PERIPH_BASE) && (slot_off < WINDOW_SIZE);
        hit_ram     = !hit_status && !hit_slot && (addr_i < RAM_BYTES);
        // Slots and status are word-only; RAM takes any aligned size.
        ok          = !misalign && (hit_ram || ((hit_status || hit_slot) && (sz == WORD)));
        store_ok    = we_i && ok;
        load_issue  = re_i && !we_i;
        err_now     = (we_i || re_i) && (!ok || (we_i && re_i));
        status_wr   = store_ok && hit_status;
        if (!ok)           load_target = T_ERR;
        else if (hit_ram)  load_target = T_RAM;
        else if (hit_slot) load_target = T_SLOT;
        else               load_target = T_STATUS;
    end

    // Slot one-hot and read-data mux over the packed peripheral bus.
    always_comb begin
        slot_onehot = '0;
        slot_rdata  = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (slot_idx == SW'(k)) begin
                slot_onehot[k] = 1'b1;
                slot_rdata     = p_rdata_i[32*k +: 32];
            end
        end
    end

    // Combinational RAM port; writes only for an accepted RAM store.
    always_comb begin
        ram_addr_o = addr_i[AW+1:2];
        ram_we_o   = store_ok && hit_ram && !reset;
        ram_be_o   = ram_we_o ? byte_enables(sz, lane) : 4'b0000;
        case (sz)
            BYTE:    ram_wdata_o = {4{wdata_i[7:0]}};
            HALF:    ram_wdata_o = {2{wdata_i[15:0]}};
            default: ram_wdata_o = wdata_i;
        endcase
    end

    // Load stage, error pulse and peripheral strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            ld_target <= T_RAM;
            ld_lane   <= 2'b00;
            ld_size   <= BYTE;
            ld_signed <= 1'b0;
            ld_data   <= '0;
            p_we_q    <= '0;
            p_re_q    <= '0;
            p_wdata_o <= '0;
        end else begin
            rvalid_q <= load_issue;
            err_q    <= err_now;
            p_we_q   <= (store_ok && hit_slot) ? slot_onehot : '0;
            p_re_q   <= (load_issue && ok && hit_slot) ? slot_onehot : '0;
            if (store_ok && hit_slot) begin
                p_wdata_o <= wdata_i;
            end
            if (load_issue) begin
                ld_target <= load_target;
                ld_lane   <= lane;
                ld_size   <= sz;
                ld_signed <= signed_i;
                case (load_target)
                    T_SLOT:   ld_data <= slot_rdata;
                    T_STATUS: ld_data <= status_word;
                    default:  ld_data <= '0;
                endcase
            end
        end
    end

    // Sticky error status; a status write clears first, a same-cycle error then counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count     <= '0;
            last_err_addr <= '0;
        end else if (status_wr) begin
            err_count     <= err_now ? 8'd1 : 8'd0;
            last_err_addr <= err_now ? addr_i[15:0] : 16'h0000;
        end else if (err_now) begin
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            last_err_addr <= addr_i[15:0];
        end
    end

    assign fmt_src = (ld_target == T_RAM) ? ram_rdata_i : ld_data;

    load_formatter u_fmt (
        .word     (fmt_src),
        .lane     (ld_lane),
        .size     (ld_size),
        .sign_ext (ld_signed),
        .data     (fmt_data)
    );

    // Outputs are forced low while reset is held so an in-flight response dies.
    assign rvalid_o = rvalid_q && !reset;
    assign err_o    = err_q && !reset;
    assign p_we_o   = p_we_q & {N_SLOTS{!reset}};
    assign p_re_o   = p_re_q & {N_SLOTS{!reset}};
    assign rdata_o  = (rvalid_o && (ld_target != T_ERR)) ? fmt_data : 32'h0;

endmodule

// File: tb/tb_mmio_bus_mapper.sv
// Directed bench for mmio_bus_mapper with a small synchronous RAM model and
// fixed peripheral read data.
module tb_mmio_bus_mapper;

    localparam int          RAM_DEPTH = 4096;
    localparam int          N_SLOTS   = 8;
    localparam int          AW        = 12;
    localparam logic [31:0] PB        = 32'h0000_2000;
    localparam logic [31:0] SA        = 32'h0000_2020;
    localparam logic [1:0]  SZ_B      = 2'b00;
    localparam logic [1:0]  SZ_H      = 2'b01;
    localparam logic [1:0]  SZ_W      = 2'b10;

    logic                  clk;
    logic                  reset;
    logic [31:0]           addr_i;
    logic [31:0]           wdata_i;
    logic                  we_i;
    logic                  re_i;
    logic [1:0]            size_i;
    logic                  signed_i;
    logic [31:0]           rdata_o;
    logic                  rvalid_o;
    logic                  err_o;
    logic                  ram_we_o;
    logic [3:0]            ram_be_o;
    logic [AW-1:0]         ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;
    logic [N_SLOTS-1:0]    p_we_o;
    logic [N_SLOTS-1:0]    p_re_o;
    logic [31:0]           p_wdata_o;
    logic [32*N_SLOTS-1:0] p_rdata_i;

    int n_checks;
    int n_fail;

    logic [31:0] mem [RAM_DEPTH];

    mmio_bus_mapper #(
        .RAM_DEPTH   (RAM_DEPTH),
        .N_SLOTS     (N_SLOTS),
        .PERIPH_BASE (PB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .we_i        (we_i),
        .re_i        (re_i),
        .size_i      (size_i),
        .signed_i    (signed_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .err_o       (err_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .p_we_o      (p_we_o),
        .p_re_o      (p_re_o),
        .p_wdata_o   (p_wdata_o),
        .p_rdata_i   (p_rdata_i)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM model: byte-lane write, registered read
    always @(posedge clk) begin
        if (ram_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] = ram_wdata_o[8*b +: 8];
            end
        end
        ram_rdata_i <= mem[ram_addr_o];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] a,
                         input logic [1:0] sz, input logic sg, input logic [31:0] wd);
        we_i     = we;
        re_i     = re;
        addr_i   = a;
        size_i   = sz;
        signed_i = sg;
        wdata_i  = wd;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        ram_rdata_i = 32'h0;
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'h0;
        for (int k = 0; k < N_SLOTS; k++) p_rdata_i[32*k +: 32] = 32'h0000_1000 + 32'(k);
        p_rdata_i[32*3 +: 32] = 32'h0000_1234;
        reset = 1'b1;
        idle();
        repeat (3) tick();

        // Reset state, including gated RAM write enable
        drive(1'b1, 1'b0, 32'h10, SZ_W, 1'b0, 32'h1111_1111);
        #1;
        check("rst_ram_we", 32'(ram_we_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_p_we", 32'(p_we_o), 32'h0);
        check("rst_p_re", 32'(p_re_o), 32'h0);
        check("rst_p_wdata", p_wdata_o, 32'h0);
        idle();
        tick();
        reset = 1'b0;
        tick();

        // Word store then word load
        drive(1'b1, 1'b0, 32'h10, SZ_W, 1'b0, 32'hDEAD_BEEF);
        #1;
        check("sw_we", 32'(ram_we_o), 32'h1);
        check("sw_be", 32'(ram_be_o), 32'hF);
        check("sw_addr", 32'(ram_addr_o), 32'h4);
        check("sw_wdata", ram_wdata_o, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b1, 32'h10, SZ_W, 1'b0, 32'h0);
        #1;
        check("lw_no_rvalid_yet", 32'(rvalid_o), 32'h0);
        tick();
        idle();
        check("lw_rvalid", 32'(rvalid_o), 32'h1);
        check("lw_rdata", rdata_o, 32'hDEAD_BEEF);
        check("lw_err", 32'(err_o), 32'h0);
        tick();
        check("lw_rvalid_drop", 32'(rvalid_o), 32'h0);

        // Byte store, then back-to-back lb / lbu / lh
        drive(1'b1, 1'b0, 32'h13, SZ_B, 1'b0, 32'h0000_0080);
        #1;
        check("sb_be", 32'(ram_be_o), 32'h8);
        check("sb_wdata", ram_wdata_o, 32'h8080_8080);
        tick();
        drive(1'b0, 1'b1, 32'h13, SZ_B, 1'b1, 32'h0);
        tick();
        check("lb_rvalid", 32'(rvalid_o), 32'h1);
        check("lb_rdata", rdata_o, 32'hFFFF_FF80);
        drive(1'b0, 1'b1, 32'h13, SZ_B, 1'b0, 32'h0);
        tick();
        check("lbu_rvalid", 32'(rvalid_o), 32'h1);
        check("lbu_rdata", rdata_o, 32'h0000_0080);
        drive(1'b0, 1'b1, 32'h12, SZ_H, 1'b1, 32'h0);
        tick();
        idle();
        check("lh_rvalid", 32'(rvalid_o), 32'h1);
        check("lh_rdata", rdata_o, 32'hFFFF_80AD);

        // Half store at offset 2, then lhu
        drive(1'b1, 1'b0, 32'h16, SZ_H, 1'b0, 32'h0000_BEEF);
        #1;
        check("sh_be", 32'(ram_be_o), 32'hC);
        check("sh_wdata", ram_wdata_o, 32'hBEEF_BEEF);
        tick();
        drive(1'b0, 1'b1, 32'h16, SZ_H, 1'b0, 32'h0);
        tick();
        idle();
        check("lhu_rdata", rdata_o, 32'h0000_BEEF);

        // Slot store: strobe one cycle later, for one cycle
        drive(1'b1, 1'b0, PB + 32'h8, SZ_W, 1'b0, 32'h5);
        #1;
        check("pst_no_ram_we", 32'(ram_we_o), 32'h0);
        check("pst_no_p_we_yet", 32'(p_we_o), 32'h0);
        tick();
        idle();
        check("pst_p_we", 32'(p_we_o), 32'h04);
        check("pst_p_wdata", p_wdata_o, 32'h5);
        check("pst_err", 32'(err_o), 32'h0);
        tick();
        check("pst_p_we_drop", 32'(p_we_o), 32'h0);

        // Slot 3 load
        drive(1'b0, 1'b1, PB + 32'hC, SZ_W, 1'b0, 32'h0);
        tick();
        idle();
        check("pld_rvalid", 32'(rvalid_o), 32'h1);
        check("pld_rdata", rdata_o, 32'h0000_1234);
        check("pld_p_re", 32'(p_re_o), 32'h08);
        tick();
        check("pld_p_re_drop", 32'(p_re_o), 32'h0);

        // Misaligned word load
        drive(1'b0, 1'b1, 32'h2, SZ_W, 1'b0, 32'h0);
        #1;
        check("mis_ram_we", 32'(ram_we_o), 32'h0);
        tick();
        idle();
        check("mis_err", 32'(err_o), 32'h1);
        check("mis_rvalid", 32'(rvalid_o), 32'h1);
        check("mis_rdata", rdata_o, 32'h0);
        check("mis_p_re", 32'(p_re_o), 32'h0);
        check("mis_p_we", 32'(p_we_o), 32'h0);
        tick();
        check("mis_err_drop", 32'(err_o), 32'h0);

        // Status read after one error
        drive(1'b0, 1'b1, SA, SZ_W, 1'b0, 32'h0);
        tick();
        idle();
        check("stat1_rvalid", 32'(rvalid_o), 32'h1);
        check("stat1_rdata", rdata_o, 32'h0100_0002);
        check("stat1_err", 32'(err_o), 32'h0);

        // Sub-word slot load is rejected
        drive(1'b0, 1'b1, PB + 32'h8, SZ_B, 1'b0, 32'h0);
        tick();
        idle();
        check("subslot_err", 32'(err_o), 32'h1);
        check("subslot_rvalid", 32'(rvalid_o), 32'h1);
        check("subslot_rdata", rdata_o, 32'h0);
        check("subslot_p_re", 32'(p_re_o), 32'h0);

        // Unmapped load
        drive(1'b0, 1'b1, 32'h0000_8000, SZ_W, 1'b0, 32'h0);
        tick();
        idle();
        check("unmap_err", 32'(err_o), 32'h1);
        check("unmap_rdata", rdata_o, 32'h0);

        // 300 misaligned stores saturate the counter
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 32'h1, SZ_W, 1'b0, 32'hFFFF_FFFF);
            tick();
        end
        idle();
        check("sat_err", 32'(err_o), 32'h1);
        check("sat_mem_untouched", mem[0], 32'h0);
        drive(1'b0, 1'b1, SA, SZ_W, 1'b0, 32'h0);
        tick();
        idle();
        check("sat_status", rdata_o, 32'hFF00_0001);

        // Status write clears it
        drive(1'b1, 1'b0, SA, SZ_W, 1'b0, 32'hFFFF_FFFF);
        tick();
        drive(1'b0, 1'b1, SA, SZ_W, 1'b0, 32'h0);
        tick();
        idle();
        check("clr_status", rdata_o, 32'h0);

        // Simultaneous store and load
        drive(1'b1, 1'b1, 32'h20, SZ_W, 1'b0, 32'hCAFE_F00D);
        #1;
        check("wr_re_ram_we", 32'(ram_we_o), 32'h1);
        check("wr_re_be", 32'(ram_be_o), 32'hF);
        tick();
        idle();
        check("wr_re_err", 32'(err_o), 32'h1);
        check("wr_re_no_rvalid", 32'(rvalid_o), 32'h0);
        drive(1'b0, 1'b1, 32'h20, SZ_W, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, SA, SZ_W, 1'b0, 32'h0);
        check("wr_re_stored", rdata_o, 32'hCAFE_F00D);
        tick();
        idle();
        check("wr_re_status", rdata_o, 32'h0100_0020);

        // Status write combined with an error: clear, then count the new error
        drive(1'b1, 1'b1, SA, SZ_W, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, SA, SZ_W, 1'b0, 32'h0);
        tick();
        idle();
        check("clr_err_status", rdata_o, 32'h0100_2020);

        // Reset right after a load and right after a slot store
        drive(1'b0, 1'b1, 32'h10, SZ_W, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        idle();
        #1;
        check("rst_kill_rvalid", 32'(rvalid_o), 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, PB, SZ_W, 1'b0, 32'h77);
        tick();
        reset = 1'b1;
        idle();
        #1;
        check("rst_kill_p_we", 32'(p_we_o), 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b1, SA, SZ_W, 1'b0, 32'h0);
        tick();
        idle();
        check("rst_status", rdata_o, 32'h0);
        check("rst_status_rvalid", 32'(rvalid_o), 32'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
